// File: rtl/ssd_scan_driver.sv
// 4-digit seven-segment scan driver with per-frame snapshot, leading-zero blanking (SSD_LZ_BLANK_EN) and blink.
// Latency: segs/ssd_ctl are registered, one edge after idx/snapshot update; each slot is held SCAN_DIV cycles.
// Backpressure: none; free-running display sink, inputs sampled only at frame wrap.
module ssd_scan_driver #(
   parameter int SCAN_DIV     = 100000,
   parameter int BLINK_FRAMES = 125
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] dig3,
   input  logic [3:0] dig2,
   input  logic [3:0] dig1,
   input  logic [3:0] dig0,
   input  logic       blank_lz,
   input  logic       blink_en,
   output logic [7:0] segs,
   output logic [3:0] ssd_ctl
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [PW-1:0]     pcnt;
   logic [1:0]        idx;
   logic [FW-1:0]     fcnt;
   logic              phase;
   logic [3:0][3:0]   snap;
   logic              tick;
   logic              wrap;
   logic [3:0]        cur_dig;
   logic              lz_blank;
   logic [7:0]        segs_nxt;
   logic [3:0]        ctl_nxt;

   function automatic logic [7:0] glyph(input logic [3:0] d);
      logic [7:0] g;
      case (d)
         4'd0:    g = 8'b0000_0011;
         4'd1:    g = 8'b1001_1111;
         4'd2:    g = 8'b0010_0101;
         4'd3:    g = 8'b0000_1101;
         4'd4:    g = 8'b1001_1001;
         4'd5:    g = 8'b0100_1001;
         4'd6:    g = 8'b0100_0001;
         4'd7:    g = 8'b0001_1111;
         4'd8:    g = 8'b0000_0001;
         4'd9:    g = 8'b0000_1001;
         4'd15:   g = 8'hFF;
         default: g = 8'b1111_1101;
      endcase
      return g;
   endfunction

   assign tick = (pcnt == PW'(SCAN_DIV - 1));
   assign wrap = tick && (idx == 2'd3);

`ifndef SSD_LZ_BLANK_EN
   logic unused_blank_lz;
   assign unused_blank_lz = blank_lz;
`endif

   always_comb begin
      cur_dig  = snap[idx];
      lz_blank = 1'b0;
`ifdef SSD_LZ_BLANK_EN
      // A slot blanks only if it and every digit to its left are zero.
      case (idx)
         2'd3:    lz_blank = blank_lz && (snap[3] == 4'd0);
         2'd2:    lz_blank = blank_lz && (snap[3] == 4'd0) && (snap[2] == 4'd0);
         2'd1:    lz_blank = blank_lz && (snap[3] == 4'd0) && (snap[2] == 4'd0) && (snap[1] == 4'd0);
         default: lz_blank = 1'b0;
      endcase
`endif
      segs_nxt = lz_blank ? 8'hFF : glyph(cur_dig);
      ctl_nxt  = phase ? 4'b1111 : ~(4'b0001 << idx);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt    <= '0;
         idx     <= 2'd0;
         fcnt    <= '0;
         phase   <= 1'b0;
         snap    <= {4{4'hF}};
         segs    <= 8'hFF;
         ssd_ctl <= 4'b1111;
      end else begin
         pcnt <= tick ? '0 : pcnt + PW'(1);
         if (tick) begin
            idx <= idx + 2'd1;
         end
         if (wrap) begin
            snap <= {dig3, dig2, dig1, dig0};
         end
         if (!blink_en) begin
            fcnt  <= '0;
            phase <= 1'b0;
         end else if (wrap) begin
            if (fcnt == FW'(BLINK_FRAMES - 1)) begin
               fcnt  <= '0;
               phase <= ~phase;
            end else begin
               fcnt <= fcnt + FW'(1);
            end
         end
         segs    <= segs_nxt;
         ssd_ctl <= ctl_nxt;
      end
   end

endmodule
